// File: rtl/nibble_serial_adder.sv
// Serial adder that sums two WIDTH-bit operands one nibble per clock through a
// single 4-bit ripple-carry slice, reporting sum, carry-out and signed overflow.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [3:0] sum;
        logic       c_msb_in;   // carry into bit 3, needed for signed overflow
        logic       c_msb_out;
    } slice_t;

    // One 4-bit ripple-carry slice, unrolled so each carry is a distinct net.
    function automatic slice_t rca4(input logic [3:0] a, input logic [3:0] b,
                                    input logic ci);
        slice_t r;
        logic   c1, c2, c3, c4;
        r.sum[0] = a[0] ^ b[0] ^ ci;
        c1       = (a[0] & b[0]) | (ci & (a[0] ^ b[0]));
        r.sum[1] = a[1] ^ b[1] ^ c1;
        c2       = (a[1] & b[1]) | (c1 & (a[1] ^ b[1]));
        r.sum[2] = a[2] ^ b[2] ^ c2;
        c3       = (a[2] & b[2]) | (c2 & (a[2] ^ b[2]));
        r.sum[3] = a[3] ^ b[3] ^ c3;
        c4       = (a[3] & b[3]) | (c3 & (a[3] ^ b[3]));
        r.c_msb_in  = c3;
        r.c_msb_out = c4;
        return r;
    endfunction

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               c_out_q, c_out_d;
    logic               ovf_q, ovf_d;

    logic               last_nibble;
    slice_t             slice;

    assign last_nibble = (idx_q == IDX_W'(N - 1));
    assign slice       = rca4(x_q[int'(idx_q) * 4 +: 4],
                              y_q[int'(idx_q) * 4 +: 4], carry_q);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default at the top of the block
    // so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start)       state_d = S_ADD;
            S_ADD:  if (last_nibble) state_d = S_DONE;
            S_DONE:                  state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // Outputs decoded straight from state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            S_IDLE: ;
            S_ADD:  busy = 1'b1;
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath next-state: operand capture, one nibble per ADD cycle.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        s_d     = s_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = x;
                    y_d     = y;
                    carry_d = cin;
                    idx_d   = '0;
                    s_d     = '0;
                    c_out_d = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            S_ADD: begin
                s_d[int'(idx_q) * 4 +: 4] = slice.sum;
                carry_d                   = slice.c_msb_out;
                idx_d                     = idx_q + IDX_W'(1);
                if (last_nibble) begin
                    c_out_d = slice.c_msb_out;
                    ovf_d   = slice.c_msb_in ^ slice.c_msb_out;
                    idx_d   = '0;
                end
            end
            S_DONE: ;
            default: ;
        endcase
    end

    // Control/result registers are reset; abandoned partial sums are cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            carry_q <= carry_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    // NOTE: operand registers are deliberately left without reset; they are
    // always loaded on acceptance before any ADD cycle reads them.
    always_ff @(posedge clk) begin
        x_q <= x_d;
        y_q <= y_d;
    end

    assign s     = s_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule
